ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment display scanner.
// A free-running prescaler paces the scan across NUM_DIGITS digits.
// Digit codes and decimal points are held in shadow registers loaded by a
// strobe. Per-digit enable and blink selects are applied live. All display
// outputs are registered, so they follow the scan state by one cycle.
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE_W = 16,
   parameter int BLINK_W    = 6
) (
   input  logic                    board_clk,
   input  logic                    Reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              cathodes,
   output logic                    frame_tick
);

   // The scan index is 3 bits wide for every legal NUM_DIGITS (1..8).
   // It wraps at NUM_DIGITS-1, so it never holds an out-of-range value.
   logic [PRESCALE_W-1:0]   presc;
   logic [2:0]              idx;
   logic [BLINK_W-1:0]      blink_cnt;
   logic [4*NUM_DIGITS-1:0] sh_dig;
   logic [NUM_DIGITS-1:0]   sh_dp;

   logic                    advance;
   logic                    wrap;
   logic [3:0]              cur_code;
   logic                    cur_dp;
   logic                    cur_en;
   logic                    cur_bm;
   logic                    dark;
   logic [NUM_DIGITS-1:0]   an_next;
   logic [7:0]              cath_next;

   // Segment pattern {Ca..Cg}, active-low. Code E is blank and code F is a minus sign.
   function automatic logic [6:0] seg7(input logic [3:0] code);
      case (code)
         4'h0:    seg7 = 7'b0000001;
         4'h1:    seg7 = 7'b1001111;
         4'h2:    seg7 = 7'b0010010;
         4'h3:    seg7 = 7'b0000110;
         4'h4:    seg7 = 7'b1001100;
         4'h5:    seg7 = 7'b0100100;
         4'h6:    seg7 = 7'b0100000;
         4'h7:    seg7 = 7'b0001111;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0000100;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b1100000;
         4'hC:    seg7 = 7'b0110001;
         4'hD:    seg7 = 7'b1000010;
         4'hE:    seg7 = 7'b1111111;
         default: seg7 = 7'b1111110;
      endcase
   endfunction

   assign advance = &presc;
   assign wrap    = advance && (idx == 3'(NUM_DIGITS - 1));

   // Scan timing: prescaler, digit index and the per-frame blink counter.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         presc     <= '0;
         idx       <= '0;
         blink_cnt <= '0;
      end else begin
         presc <= presc + 1'b1;
         if (advance) begin
            idx <= wrap ? 3'd0 : idx + 3'd1;
         end
         if (wrap) begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Shadow copy of the display data, captured only on the load strobe.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         sh_dig <= {NUM_DIGITS{4'hE}};
         sh_dp  <= '0;
      end else if (load) begin
         sh_dig <= digits_in;
         sh_dp  <= dp_in;
      end
   end

   // Select the current digit's data and its live enable and blink controls.
   always_comb begin
      cur_code = 4'h0;
      cur_dp   = 1'b0;
      cur_en   = 1'b0;
      cur_bm   = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == 3'(k)) begin
            cur_code = sh_dig[4*k +: 4];
            cur_dp   = sh_dp[k];
            cur_en   = digit_en[k];
            cur_bm   = blink_mask[k];
         end
      end
   end

   assign dark      = !cur_en || (cur_bm && blink_cnt[BLINK_W-1]);
   assign cath_next = dark ? 8'hFF : {seg7(cur_code), ~cur_dp};

   // Anode pattern: only the current digit is driven low, and only when it is lit.
   always_comb begin
      an_next = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         an_next[k] = dark || (idx != 3'(k));
      end
   end

   // Registered display outputs; frame_tick marks the edge that wrapped the scan.
   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         an         <= '1;
         cathodes   <= 8'hFF;
         frame_tick <= 1'b0;
      end else begin
         an         <= an_next;
         cathodes   <= cath_next;
         frame_tick <= wrap;
      end
   end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: randomized and directed checks of ssd_scan_ctrl.
// The main instance has 4 digits, a 2-bit prescaler and a 2-bit blink counter.
// A second instance has a single digit.
// The reference model works from elapsed clock edges since reset:
//   each digit is shown for 4 edges,
//   a frame is 16 edges,
//   and the blink phase is bit 1 of the completed frame count.
module tb_ssd_scan_ctrl;

   logic        board_clk;
   logic        Reset;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic [3:0]  blink_mask;
   logic [3:0]  an;
   logic [7:0]  cathodes;
   logic        frame_tick;
   logic [0:0]  an1;
   logic [7:0]  cathodes1;
   logic        frame_tick1;

   int total = 0;
   int bad   = 0;

   // Model state: edges since reset release, and the shadow copy of the display data.
   int          e = 0;
   logic [15:0] sh_dig = 16'hEEEE;
   logic [3:0]  sh_dp  = 4'h0;
   logic [6:0]  seg_tab [16];
   logic [7:0]  lit28 [4];
   logic        chk28 = 1'b0;
   int          ft_count = 0;

   ssd_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE_W(2), .BLINK_W(2)) dut (
      .board_clk (board_clk),
      .Reset     (Reset),
      .load      (load),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .digit_en  (digit_en),
      .blink_mask(blink_mask),
      .an        (an),
      .cathodes  (cathodes),
      .frame_tick(frame_tick)
   );

   ssd_scan_ctrl #(.NUM_DIGITS(1), .PRESCALE_W(2), .BLINK_W(2)) dut1 (
      .board_clk (board_clk),
      .Reset     (Reset),
      .load      (1'b0),
      .digits_in (4'h0),
      .dp_in     (1'b0),
      .digit_en  (1'b1),
      .blink_mask(1'b0),
      .an        (an1),
      .cathodes  (cathodes1),
      .frame_tick(frame_tick1)
   );

   // Clock
   initial begin
      board_clk = 1'b0;
      forever #5 board_clk = ~board_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_an"},  32'(an),         32'hF);
      chk({tag, "_cat"}, 32'(cathodes),   32'hFF);
      chk({tag, "_ft"},  32'(frame_tick), 32'h0);
      chk({tag, "_an1"}, 32'(an1),        32'h1);
      chk({tag, "_ft1"}, 32'(frame_tick1), 32'h0);
   endtask

   // One clock: the model predicts from its pre-edge state, then the outputs are checked at the negedge.
   task automatic step();
      int         kk;
      int         frames;
      logic       phase;
      logic       dark;
      logic [3:0] exp_an;
      logic [7:0] exp_cat;
      logic       exp_ft;
      @(posedge board_clk);
      e++;
      kk      = ((e - 1) / 4) % 4;
      frames  = (e - 1) / 16;
      phase   = ((frames / 2) % 2) == 1;
      dark    = !digit_en[kk] || (blink_mask[kk] && phase);
      exp_an  = dark ? 4'hF : 4'(~(4'b0001 << kk));
      exp_cat = dark ? 8'hFF : {seg_tab[sh_dig[kk*4 +: 4]], ~sh_dp[kk]};
      exp_ft  = (e % 16) == 0;
      if (load) begin
         sh_dig = digits_in;
         sh_dp  = dp_in;
      end
      @(negedge board_clk);
      chk("an",       32'(an),         32'(exp_an));
      chk("cathodes", 32'(cathodes),   32'(exp_cat));
      chk("frame",    32'(frame_tick), 32'(exp_ft));
      chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      chk("an1",      32'(an1),        32'h0);
      chk("cath1",    32'(cathodes1),  32'hFF);
      chk("frame1",   32'(frame_tick1), 32'((e % 4) == 0));
      if (chk28) chk("lit28", 32'(cathodes), 32'(lit28[kk]));
      if (frame_tick) ft_count++;
   endtask

   // Assert Reset off the clock edge, confirm the outputs clear at once, then restart the model.
   task automatic do_reset();
      Reset = 1'b1;
      #1;
      chk_reset_vals("rst_async");
      @(negedge board_clk);
      @(negedge board_clk);
      chk_reset_vals("rst_hold");
      Reset  = 1'b0;
      e      = 0;
      sh_dig = 16'hEEEE;
      sh_dp  = 4'h0;
   endtask

   initial begin
      seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
      seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
      seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
      seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
      seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
      seg_tab[14] = 7'b1111111; seg_tab[15] = 7'b1111110;
      lit28[0] = 8'b00000011; lit28[1] = 8'b10011110;
      lit28[2] = 8'b00100101; lit28[3] = 8'b11111101;

      Reset      = 1'b1;
      load       = 1'b0;
      digits_in  = 16'h0;
      dp_in      = 4'h0;
      digit_en   = 4'hF;
      blink_mask = 4'h0;
      repeat (3) @(negedge board_clk);
      chk_reset_vals("reset");
      Reset = 1'b0;

      // Nothing loaded and every digit enabled: the anodes walk across the digits and the cathodes stay blank.
      repeat (20) step();

      // Load F210 with the decimal point on digit 1, then count frame ticks.
      digits_in = 16'hF210;
      dp_in     = 4'b0010;
      load      = 1'b1;
      step();
      load      = 1'b0;
      digits_in = 16'h0;
      dp_in     = 4'h0;
      step();
      chk28    = 1'b1;
      ft_count = 0;
      repeat (32) step();
      chk28 = 1'b0;
      chk("ft_count", 32'(ft_count), 32'd2);

      // Digit 2 disabled.
      digit_en = 4'b1011;
      repeat (16) step();

      // Digit 0 blinks: dark in frames 2 and 3 of every 4.
      digit_en   = 4'hF;
      blink_mask = 4'b0001;
      repeat (64) step();
      blink_mask = 4'h0;

      // A load on the advance edge, then Reset partway through digit 2.
      for (int i = 0; i < 8 && ((e + 1) % 4) != 0; i++) step();
      digits_in = 16'h9876;
      dp_in     = 4'b1000;
      load      = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 32 && !(((e / 4) % 4) == 2 && (e % 4) == 1); i++) step();
      chk("mid_digit2", 32'((e / 4) % 4), 32'd2);
      do_reset();
      repeat (20) step();

      // Random data, loads, enables and blink selects.
      for (int i = 0; i < 400; i++) begin
         load       = ($urandom_range(0, 7) == 0);
         digits_in  = 16'($urandom);
         dp_in      = 4'($urandom_range(0, 15));
         digit_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         blink_mask = 4'($urandom_range(0, 15));
         step();
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
